// File: rtl/pwm_sequencer.sv
// rtl/pwm_sequencer.sv - PWM DataPath sequencer: config handshake, start/stop, period counting
module pwm_sequencer #(
  parameter int C = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         oneShot,
  input  logic [C-1:0] pulseCount,
  input  logic         cfgValid,
  output logic         cfgReady,
  output logic         cfgApplied,
  input  logic         CNTzero,
  output logic         write,
  output logic         writeCNT,
  output logic         enbCNT,
  output logic         busy,
  output logic         done,
  output logic [C-1:0] periodCount
);

  typedef enum logic [1:0] {IDLE, UPDATE, LOAD, RUN} state_t;

  state_t       state;
  logic         cfg_loaded;
  logic         pending;
  logic         stop_req;
  logic         run_ctx;
  logic         one_shot_q;
  logic [C-1:0] pulse_q;

  logic         accept;
  logic         pend_now;
  logic         boundary;
  logic         last_period;
  logic         exit_run;
  logic [C-1:0] next_count;

  // Handshake, period-boundary and run-exit decisions for the current cycle
  always_comb begin
    accept      = cfgValid && cfgReady;
    pend_now    = pending || accept;
    boundary    = (state == RUN) && CNTzero && enbCNT;
    next_count  = periodCount + C'(1);
    last_period = one_shot_q && (pulse_q != '0) && (next_count == pulse_q);
    exit_run    = stop_req || stop || last_period;
  end

  // Sequencer FSM; every output is a register updated alongside the state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      write       <= 1'b0;
      writeCNT    <= 1'b0;
      enbCNT      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfgApplied  <= 1'b0;
      cfgReady    <= 1'b1;
      periodCount <= '0;
      cfg_loaded  <= 1'b0;
      pending     <= 1'b0;
      stop_req    <= 1'b0;
      run_ctx     <= 1'b0;
      one_shot_q  <= 1'b0;
      pulse_q     <= '0;
    end else begin
      write      <= 1'b0;
      writeCNT   <= 1'b0;
      cfgApplied <= 1'b0;
      done       <= 1'b0;
      if (state != IDLE && stop) stop_req <= 1'b1;

      case (state)
        IDLE: begin
          cfgReady <= 1'b1;
          // A deferred or newly offered config is applied before start is honoured
          if (pend_now) begin
            state    <= UPDATE;
            write    <= 1'b1;
            busy     <= 1'b1;
            cfgReady <= 1'b0;
            pending  <= 1'b0;
            run_ctx  <= 1'b0;
          end else if (start && cfg_loaded && !stop) begin
            state       <= LOAD;
            writeCNT    <= 1'b1;
            busy        <= 1'b1;
            periodCount <= '0;
            one_shot_q  <= oneShot;
            pulse_q     <= pulseCount;
            stop_req    <= 1'b0;
          end
        end

        UPDATE: begin
          // Registers are written at the end of this cycle, so the source is released after it
          cfgApplied <= 1'b1;
          cfg_loaded <= 1'b1;
          cfgReady   <= 1'b0;
          if (run_ctx) begin
            state    <= LOAD;
            writeCNT <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        LOAD: begin
          state    <= RUN;
          enbCNT   <= 1'b1;
          pending  <= pend_now;
          cfgReady <= !pend_now;
        end

        RUN: begin
          if (boundary) begin
            periodCount <= next_count;
            enbCNT      <= 1'b0;
            if (exit_run) begin
              state    <= IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
              stop_req <= 1'b0;
              pending  <= pend_now;
              cfgReady <= 1'b1;
            end else if (pend_now) begin
              state    <= UPDATE;
              write    <= 1'b1;
              pending  <= 1'b0;
              run_ctx  <= 1'b1;
              cfgReady <= 1'b0;
            end else begin
              state    <= LOAD;
              writeCNT <= 1'b1;
              cfgReady <= 1'b1;
            end
          end else begin
            pending  <= pend_now;
            cfgReady <= !pend_now;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_sequencer.sv
// tb/tb_pwm_sequencer.sv - self-checking bench for pwm_sequencer with a behavioural DataPath
module tb_pwm_sequencer;
  localparam int C = 4;

  logic         clock, reset, start, stop, oneShot, cfgValid, CNTzero;
  logic [C-1:0] pulseCount;
  logic         cfgReady, cfgApplied, write, writeCNT, enbCNT, busy, done;
  logic [C-1:0] periodCount;

  logic [15:0]  pwm_period;
  logic [15:0]  period_reg, dp_cnt;

  pwm_sequencer #(.C(C)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .oneShot(oneShot),
    .pulseCount(pulseCount), .cfgValid(cfgValid), .cfgReady(cfgReady),
    .cfgApplied(cfgApplied), .CNTzero(CNTzero), .write(write), .writeCNT(writeCNT),
    .enbCNT(enbCNT), .busy(busy), .done(done), .periodCount(periodCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural DataPath: period register plus down-counter sharing the reset net
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      period_reg <= '0;
      dp_cnt     <= '0;
    end else begin
      if (write) period_reg <= pwm_period;
      if (writeCNT) dp_cnt <= period_reg;
      else if (enbCNT) dp_cnt <= dp_cnt - 16'd1;
    end
  end
  assign CNTzero = (dp_cnt == 16'd0);

  int n_checks = 0;
  int n_pass   = 0;
  int overlaps = 0;
  int n_wcnt   = 0;
  int n_applied = 0;
  logic [C-1:0] exp_q[$];

  function automatic void check(string name, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  // Monitor: strobe exclusivity, pulse counters and the done scoreboard
  always @(negedge clock) begin
    if ((write && writeCNT) || (enbCNT && (write || writeCNT))) overlaps++;
    if (writeCNT) n_wcnt++;
    if (cfgApplied) n_applied++;
    if (done) begin
      if (exp_q.size() == 0) check("unexpected_done", 1, 0);
      else check("done_periodCount", periodCount, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_cfg(input int p);
    int i;
    pwm_period = 16'(p);
    cfgValid = 1'b1;
    i = 0;
    while (!cfgApplied && i < 40) begin step(); i++; end
    check("cfg_applied_seen", cfgApplied, 1);
    cfgValid = 1'b0;
    step();
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!done && n < bound) begin step(); n++; end
    check("done_within_bound", done, 1);
  endtask

  typedef struct {
    int period;
    int pulses;
    int exp_busy;
    int exp_pc;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int n, busy_cyc, wraps, xs;
    logic [C-1:0] prev, pc;

    vecs[0] = '{period: 4, pulses: 3, exp_busy: 18, exp_pc: 3};
    vecs[1] = '{period: 0, pulses: 2, exp_busy: 4,  exp_pc: 2};
    vecs[2] = '{period: 2, pulses: 1, exp_busy: 4,  exp_pc: 1};
    vecs[3] = '{period: 1, pulses: 5, exp_busy: 15, exp_pc: 5};

    reset = 1'b0; start = 1'b0; stop = 1'b0; oneShot = 1'b0; pulseCount = '0;
    cfgValid = 1'b0; pwm_period = '0;
    repeat (3) step();
    check("rst_cfgReady", cfgReady, 1);
    check("rst_busy", busy, 0);
    check("rst_periodCount", periodCount, 0);
    check("rst_strobes", {write, writeCNT, enbCNT, done, cfgApplied}, 0);
    reset = 1'b1;
    step();

    // Reset in the middle of a continuous run
    do_cfg(2);
    oneShot = 1'b0; start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (periodCount != 4'd5 && n < 100) begin step(); n++; end
    check("reached_pc5", periodCount, 5);
    #2 reset = 1'b0;
    #1;
    check("async_rst_outputs", {busy, write, writeCNT, enbCNT, done, cfgApplied}, 0);
    check("async_rst_ready", cfgReady, 1);
    check("async_rst_pc", periodCount, 0);
    step(); step();
    reset = 1'b1;
    step();

    // Start before any configuration is ignored
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    check("start_no_cfg_busy", busy, 0);

    // Start and stop together are ignored
    do_cfg(1);
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    step(); step();
    check("start_stop_busy", busy, 0);

    // One-shot runs from the table
    for (int v = 0; v < 4; v++) begin
      do_cfg(vecs[v].period);
      n_wcnt = 0;
      oneShot = 1'b1; pulseCount = C'(vecs[v].pulses);
      exp_q.push_back(C'(vecs[v].exp_pc));
      start = 1'b1; step(); start = 1'b0;
      busy_cyc = 0; n = 0;
      while (!done && n < 200) begin
        if (busy) busy_cyc++;
        step(); n++;
      end
      check("oneshot_done", done, 1);
      check("oneshot_busy_cycles", busy_cyc, vecs[v].exp_busy);
      check("oneshot_pc", periodCount, vecs[v].exp_pc);
      check("oneshot_writeCNT", n_wcnt, vecs[v].pulses);
      check("oneshot_busy_after", busy, 0);
      step();
    end
    oneShot = 1'b0; pulseCount = '0;

    // Continuous P=8, reconfigure to P=3 mid-period
    do_cfg(8);
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    n_applied = 0;
    pwm_period = 16'd3; cfgValid = 1'b1;
    step();
    check("pending_ready_low", cfgReady, 0);
    check("still_running", enbCNT, 1);
    n = 0;
    while (!cfgApplied && n < 40) begin step(); n++; end
    check("reconf_applied", cfgApplied, 1);
    check("reconf_writeCNT_follows", writeCNT, 1);
    cfgValid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      step(); n++;
      while (!writeCNT && n < 30) begin step(); n++; end
      check("new_period_length", n, 5);
    end
    check("applied_once", n_applied, 1);
    pc = periodCount;
    exp_q.push_back(pc + C'(1));
    stop = 1'b1; step(); stop = 1'b0;
    wait_done(40, n);
    step();

    // Graceful stop with counter at 5
    do_cfg(8);
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (!(dp_cnt == 16'd5 && enbCNT) && n < 40) begin step(); n++; end
    check("reached_cnt5", dp_cnt, 5);
    pc = periodCount;
    exp_q.push_back(pc + C'(1));
    stop = 1'b1; step(); stop = 1'b0;
    check("stop_enb_continues", enbCNT, 1);
    wait_done(40, n);
    check("stop_latency", n, 5);
    step();

    // Period 0 continuous: wrap of the period counter
    do_cfg(0);
    start = 1'b1; step(); start = 1'b0;
    wraps = 0; xs = 0; prev = periodCount;
    for (int k = 0; k < 40; k++) begin
      step();
      if ($isunknown(periodCount)) xs++;
      if (prev == 4'd15 && periodCount == 4'd0) wraps++;
      prev = periodCount;
    end
    check("p0_wraps", wraps, 1);
    check("p0_no_x", xs, 0);
    check("p0_busy", busy, 1);
    pc = periodCount;
    exp_q.push_back(pc + C'(1));
    stop = 1'b1; step(); stop = 1'b0;
    wait_done(20, n);
    step(); step();

    check("no_strobe_overlap", overlaps, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
